nand_cpu_core: RTL and testbench
================================

Name: nand_cpu_core

Overview:
- Minimal multi-cycle 16-bit CPU whose only logic operation is NAND. Addition and all other logic are built in software from NAND and shifts.
- Contains its own unified block-organised memory holding both program and data; there is no external bus.
- Runs from PC 0 after reset and raises halt when it executes HALT.
- Top-level of the design; the bench preloads and inspects memory hierarchically.

Parameters:
- PC_SIZE, 16, instruction-index width; instruction space is 2^PC_SIZE 16-bit words.
- CACHE_BLOCK_SIZE, 64, memory row width in bits (multiple of 16, at least 64).
- MEM_WIDTH, derived = max(PC_SIZE, 17), halfword-address width; the memory holds 2^MEM_WIDTH halfwords.

Ports:
- clk  in  1  single clock, rising edge.
- n_rst  in  1  asynchronous, active-high reset (n_rst=1 holds the core in reset).
- halt  out  1  high once HALT has executed; stays high until reset.

Behaviour:
- Memory: instance named MEMORY with array core[2^MEM_WIDTH / (CACHE_BLOCK_SIZE/16)] of CACHE_BLOCK_SIZE bits.
  - Halfword k of a row occupies the most-significant end first: halfword 0 = bits [CBS-1 : CBS-16].
  - Program region: rows 0 .. DATA_OFFSET-1, where DATA_OFFSET = 2^(MEM_WIDTH - log2(CBS/16) - 1). This is 16384 for the defaults.
  - Data region: halfword address D maps to row DATA_OFFSET + D/(CBS/16), slot D mod (CBS/16).
  - Synchronous 1-cycle read, synchronous write. Contents are not cleared by reset.
- Registers: r0..r7, 16 bits each. r0 reads 0 and writes to it are discarded.
- Instruction fields: op = [15:12], rd = [11:9], ra = [8:6], rb = [5:3], imm8 = [7:0], off9 = [8:0] (signed).
- Opcodes:
  - 0 NAND: rd = ~(ra & rb).
  - 1 SHL: rd = ra << 1.
  - 2 SHR: rd = ra >> 1, logical.
  - 3 LIL: rd = {8'h00, imm8}.
  - 4 LUI: rd = {imm8, rd[7:0]}.
  - 5 LD: rd = data[ra].
  - 6 ST: data[ra] = rd.
  - 7 BZ: if rd == 0 then pc = pc + 1 + sext(off9).
  - 8 BNZ: if rd != 0 then pc = pc + 1 + sext(off9).
  - 9 JMP: pc = pc + 1 + sext(off9).
  - F HALT.
  - A..E: NOP.
- Arithmetic: all results are 16 bits and wrap. PC arithmetic wraps modulo 2^PC_SIZE.
- FSM states: FETCH, DECODE, EXEC, MEM, HALTED.
  - FETCH: issue instruction read. DECODE: latch the instruction.
  - EXEC: ALU/branch ops finish here (3 cycles per instruction). LD/ST go on to MEM (4 cycles).
  - HALT moves to HALTED; halt is asserted combinationally from HALTED.
  - HALTED holds forever: no fetch, no writes.
- Store granularity: a store writes only the addressed 16-bit slot; the other slots of the row are untouched.
- Timing: no data access occurs earlier than the 2nd cycle after reset release, so the bench may poke data in the release cycle.
- Reset (async assert, sync release): pc = 0, all registers = 0, state = FETCH, halt = 0. Reset mid-execution abandons the instruction; any write not yet clocked is lost.
- Instruction fetch uses PC as the halfword address within the program region.

Decomposition:
- Package nand_cpu_pkg: opcode enum, FSM state enum, PC_SIZE, CACHE_BLOCK_SIZE, MEM_WIDTH, DATA_OFFSET, and the instruction-field struct.
- One sub-module: nand_memory (the row array core, halfword read/write port, slot select), instantiated as MEMORY.
- Decode, register file and FSM stay inline in the core.

Test Plan:
- Reset: hold n_rst=1 for 2 cycles, then release -> halt=0, pc=0, first fetch from row 0 slot 0.
- HALT-only program (0xF000) -> halt rises 3 cycles after reset release and stays high for 20 cycles.
- LIL r1,0x34; LUI r1,0x12; LIL r2,1; ST r1,[r2]; HALT -> data halfword 1 = 0x1234, i.e. core[DATA_OFFSET][47:32]=0x1234.
  - Other slots of that row are unchanged.
- NAND r3,r1,r1 with r1=0x00FF, then store -> 0xFF00. SHL of 0x8001 -> 0x0002. SHR of 0x8001 -> 0x4000.
- Add program: loads op0 from data[2] and op1 from data[3] (core[DATA_OFFSET][31:0]={op0,op1}), computes the sum with a NAND/shift carry loop, stores it to data[1], then HALTs.
  - 64 random pairs, e.g. 0xFFFF+0x0001 -> 0x0000 and 0x1234+0x4321 -> 0x5555.
  - Core is reset between runs.
- Branches: BZ taken with rd=0 and not taken with rd=5; a backward BNZ loop counting 3→0; JMP off9 = -1 spins on itself (halt stays 0). Reset during the spin -> restarts at pc 0.

Source files
------------

// File: rtl/nand_cpu_pkg.sv
// Shared types and sizing for the NAND-only CPU.
// Memory geometry is derived here so core and memory agree.
package nand_cpu_pkg;

    localparam int PC_SIZE = 16;
    localparam int CACHE_BLOCK_SIZE = 64;
    localparam int MEM_WIDTH = (PC_SIZE > 17) ? PC_SIZE : 17;
    localparam int SLOTS = CACHE_BLOCK_SIZE / 16;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int ROW_W = MEM_WIDTH - SLOT_W;
    localparam int DATA_OFFSET = 2 ** (ROW_W - 1);
    localparam int DATA_BASE = DATA_OFFSET * SLOTS;

    typedef enum logic [3:0] {
        OP_NAND = 4'h0,
        OP_SHL  = 4'h1,
        OP_SHR  = 4'h2,
        OP_LIL  = 4'h3,
        OP_LUI  = 4'h4,
        OP_LD   = 4'h5,
        OP_ST   = 4'h6,
        OP_BZ   = 4'h7,
        OP_BNZ  = 4'h8,
        OP_JMP  = 4'h9,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALTED
    } state_e;

    // imm8 and off9 overlap the low fields and are sliced from the word.
    typedef struct packed {
        opcode_e    op;
        logic [2:0] rd;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [2:0] rsvd;
    } instr_t;

    function automatic logic [PC_SIZE-1:0] sext9(input logic [8:0] v);
        return {{(PC_SIZE - 9){v[8]}}, v};
    endfunction

endpackage

// File: rtl/nand_memory.sv
// Unified row-organised memory with a single halfword port.
// Halfword 0 of a row sits in its most-significant bits.
module nand_memory
    import nand_cpu_pkg::*;
(
    input  logic                 clk,
    input  logic [MEM_WIDTH-1:0] addr,
    input  logic                 we,
    input  logic [15:0]          wdata,
    output logic [15:0]          rdata
);

    localparam int ROWS = 2 ** ROW_W;
    localparam int LSB_W = SLOT_W + 4;

    logic [CACHE_BLOCK_SIZE-1:0] core [ROWS];

    logic [ROW_W-1:0]  row;
    logic [SLOT_W-1:0] slot;
    logic [LSB_W-1:0]  lsb;

    assign row  = addr[MEM_WIDTH-1:SLOT_W];
    assign slot = addr[SLOT_W-1:0];
    assign lsb  = {~slot, 4'b0000};

    always_ff @(posedge clk) begin
        if (we) begin
            core[row][lsb +: 16] <= wdata;
        end
        rdata <= core[row][lsb +: 16];
    end

endmodule

// File: rtl/nand_cpu_core.sv
// Multi-cycle 16-bit CPU whose only logic primitive is NAND.
// FETCH/DECODE/EXEC per instruction, plus MEM for loads and stores.
module nand_cpu_core
    import nand_cpu_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    output logic halt
);

    state_e               state;
    logic [PC_SIZE-1:0]   pc;
    instr_t               ir;
    logic [15:0]          regs [8];

    logic [MEM_WIDTH-1:0] mem_addr;
    logic                 mem_we;
    logic [15:0]          mem_rdata;

    logic [15:0]          va;
    logic [15:0]          vb;
    logic [15:0]          vd;
    logic [7:0]           imm8;
    logic [8:0]           off9;
    logic [MEM_WIDTH-1:0] data_addr;
    logic [PC_SIZE-1:0]   pc_seq;
    logic [PC_SIZE-1:0]   pc_br;
    logic [15:0]          alu_res;
    logic                 alu_we;
    logic                 taken;

    assign va     = regs[ir.ra];
    assign vb     = regs[ir.rb];
    assign vd     = regs[ir.rd];
    assign imm8   = ir[7:0];
    assign off9   = ir[8:0];
    assign pc_seq = pc + 1'b1;
    assign pc_br  = pc_seq + sext9(off9);
    assign halt   = (state == S_HALTED);

    assign data_addr = MEM_WIDTH'(DATA_BASE) + MEM_WIDTH'(va);

    // Only EXEC touches data; every other state reads at the PC.
    assign mem_addr = (state == S_EXEC) ? data_addr
                                         : MEM_WIDTH'(pc);
    assign mem_we   = (state == S_EXEC) && (ir.op == OP_ST);

    nand_memory MEMORY (
        .clk   (clk),
        .addr  (mem_addr),
        .we    (mem_we),
        .wdata (vd),
        .rdata (mem_rdata)
    );

    always_comb begin
        alu_res = '0;
        alu_we  = 1'b0;
        taken   = 1'b0;
        case (ir.op)
            OP_NAND: begin
                alu_res = ~(va & vb);
                alu_we  = 1'b1;
            end
            OP_SHL: begin
                alu_res = va << 1;
                alu_we  = 1'b1;
            end
            OP_SHR: begin
                alu_res = va >> 1;
                alu_we  = 1'b1;
            end
            OP_LIL: begin
                alu_res = {8'h00, imm8};
                alu_we  = 1'b1;
            end
            OP_LUI: begin
                alu_res = {imm8, vd[7:0]};
                alu_we  = 1'b1;
            end
            OP_BZ:   taken = (vd == 16'h0000);
            OP_BNZ:  taken = (vd != 16'h0000);
            OP_JMP:  taken = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ir    <= instr_t'(mem_rdata);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    pc    <= taken ? pc_br : pc_seq;
                    state <= S_FETCH;
                    if (alu_we && ir.rd != 3'd0) begin
                        regs[ir.rd] <= alu_res;
                    end
                    if (ir.op == OP_LD || ir.op == OP_ST) begin
                        state <= S_MEM;
                    end
                    if (ir.op == OP_HALT) begin
                        pc    <= pc;
                        state <= S_HALTED;
                    end
                end
                S_MEM: begin
                    if (ir.op == OP_LD && ir.rd != 3'd0) begin
                        regs[ir.rd] <= mem_rdata;
                    end
                    state <= S_FETCH;
                end
                default: state <= S_HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_nand_cpu_core.sv
// Bench for nand_cpu_core: programs are poked into memory,
// expected data rows are queued and compared once halt rises.
module tb_nand_cpu_core;
    import nand_cpu_pkg::*;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic halt;

    always #5 clk = ~clk;

    nand_cpu_core dut (
        .clk   (clk),
        .n_rst (n_rst),
        .halt  (halt)
    );

    int n_checks = 0;
    int n_pass = 0;
    logic [63:0] exp_q [$];
    logic [15:0] prog [$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [15:0] e_nand(int rd, int ra, int rb);
        return {4'h0, 3'(rd), 3'(ra), 3'(rb), 3'b000};
    endfunction

    function automatic logic [15:0] e_r(logic [3:0] op, int rd, int ra);
        return {op, 3'(rd), 3'(ra), 6'b000000};
    endfunction

    function automatic logic [15:0] e_i(logic [3:0] op, int rd,
                                        logic [7:0] imm);
        return {op, 3'(rd), 1'b0, imm};
    endfunction

    function automatic logic [15:0] e_b(logic [3:0] op, int rd, int off);
        return {op, 3'(rd), 9'(off)};
    endfunction

    task automatic poke(input int a, input logic [15:0] w);
        dut.MEMORY.core[a / SLOTS][(SLOTS - 1 - a % SLOTS) * 16 +: 16] <= w;
    endtask

    task automatic start();
        n_rst = 1'b1;
        foreach (prog[i]) poke(i, prog[i]);
        repeat (2) @(negedge clk);
        n_rst = 1'b0;
    endtask

    task automatic run(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (!halt && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (!halt) check({tag, "_timeout"}, 64'(halt), 64'd1);
    endtask

    task automatic run_row(input string tag, input int budget);
        int cyc;
        start();
        run(tag, budget, cyc);
        check(tag, dut.MEMORY.core[DATA_OFFSET], exp_q.pop_front());
    endtask

    initial begin
        int cyc;
        logic [15:0] a, b, s;
        logic [15:0] pa [$];
        logic [15:0] pb [$];

        // reset and halt latency
        prog = {16'hF000};
        #1;
        start();
        check("rst_halt", 64'(halt), 64'd0);
        check("rst_pc", 64'(dut.pc), 64'd0);
        check("rst_fetch_addr", 64'(dut.mem_addr), 64'd0);
        run("halt_only", 50, cyc);
        check("halt_latency", 64'(cyc), 64'd3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halt_hold", 64'(halt), 64'd1);
        end

        // store writes only its slot
        prog = {e_i(4'h3, 1, 8'h34), e_i(4'h4, 1, 8'h12),
                e_i(4'h3, 2, 8'h01), e_r(4'h6, 1, 2), 16'hF000};
        dut.MEMORY.core[DATA_OFFSET] <= 64'hAAAA_BBBB_CCCC_DDDD;
        exp_q.push_back(64'hAAAA_1234_CCCC_DDDD);
        run_row("store_slot", 200);

        // NAND, shifts, r0 hardwired zero
        prog = {e_i(4'h3, 1, 8'hFF), e_nand(3, 1, 1),
                e_i(4'h3, 2, 8'h00), e_r(4'h6, 3, 2),
                e_i(4'h3, 1, 8'h01), e_i(4'h4, 1, 8'h80),
                e_r(4'h1, 4, 1), e_i(4'h3, 2, 8'h01), e_r(4'h6, 4, 2),
                e_r(4'h2, 5, 1), e_i(4'h3, 2, 8'h02), e_r(4'h6, 5, 2),
                e_i(4'h3, 0, 8'h55), e_i(4'h3, 2, 8'h03),
                e_r(4'h6, 0, 2), 16'hF000};
        dut.MEMORY.core[DATA_OFFSET] <= 64'h1111_2222_3333_4444;
        exp_q.push_back(64'hFF00_0002_4000_0000);
        run_row("alu_ops", 300);

        // branches: BZ taken/not, backward BNZ loop
        prog = {e_i(4'h3, 1, 8'h00), e_b(4'h7, 1, 1),
                e_i(4'h3, 6, 8'h11), e_i(4'h3, 2, 8'h05),
                e_b(4'h7, 2, 1), e_i(4'h3, 7, 8'h22),
                e_i(4'h3, 3, 8'h04), e_i(4'h3, 4, 8'h01),
                e_r(4'h2, 3, 3), e_r(4'h1, 4, 4), e_b(4'h8, 3, -3),
                e_i(4'h3, 5, 8'h00), e_r(4'h6, 6, 5),
                e_i(4'h3, 5, 8'h01), e_r(4'h6, 7, 5),
                e_i(4'h3, 5, 8'h02), e_r(4'h6, 4, 5),
                e_i(4'h3, 5, 8'h03), e_r(4'h6, 3, 5), 16'hF000};
        dut.MEMORY.core[DATA_OFFSET] <= 64'hFFFF_FFFF_FFFF_FFFF;
        exp_q.push_back(64'h0000_0022_0008_0000);
        run_row("branches", 400);

        // software add: XOR/AND from NAND, carry shifted left
        prog = {e_i(4'h3, 4, 8'h02), e_r(4'h5, 1, 4),
                e_i(4'h3, 4, 8'h03), e_r(4'h5, 2, 4),
                e_b(4'h7, 2, 7), e_nand(3, 1, 2), e_nand(5, 3, 3),
                e_nand(6, 1, 3), e_nand(7, 2, 3), e_nand(1, 6, 7),
                e_r(4'h1, 2, 5), e_b(4'h9, 0, -8),
                e_i(4'h3, 4, 8'h01), e_r(4'h6, 1, 4), 16'hF000};
        pa = {16'hFFFF, 16'h1234, 16'h0000, 16'h8000};
        pb = {16'h0001, 16'h4321, 16'h0000, 16'h8000};
        for (int i = 0; i < 64; i++) begin
            pa.push_back(16'($urandom_range(0, 65535)));
            pb.push_back(16'($urandom_range(0, 65535)));
        end
        foreach (pa[i]) begin
            a = pa[i];
            b = pb[i];
            s = a + b;
            dut.MEMORY.core[DATA_OFFSET] <= {16'hDEAD, ~s, a, b};
            exp_q.push_back({48'h0, s});
            start();
            run("add_run", 2000, cyc);
            check("add_sum", {48'h0, dut.MEMORY.core[DATA_OFFSET][47:32]},
                  exp_q.pop_front());
        end

        // JMP -1 spins; reset mid-spin restarts at pc 0
        prog = {e_i(4'h3, 1, 8'h07), e_b(4'h9, 0, -1)};
        start();
        repeat (60) @(negedge clk);
        check("spin_halt", 64'(halt), 64'd0);
        check("spin_pc", 64'(dut.pc), 64'd1);
        check("spin_r1", 64'(dut.regs[1]), 64'd7);
        n_rst = 1'b1;
        #1;
        check("async_pc", 64'(dut.pc), 64'd0);
        check("async_r1", 64'(dut.regs[1]), 64'd0);
        @(negedge clk);
        n_rst = 1'b0;
        check("restart_addr", 64'(dut.mem_addr), 64'd0);
        repeat (3) @(negedge clk);
        check("restart_pc", 64'(dut.pc), 64'd1);
        check("restart_r1", 64'(dut.regs[1]), 64'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
